// File: rtl/pipe_pkg.sv
// Shared types and constants for the pipeline hazard controller.
// Stage indices, FSM states and forwarding-select encoding live here.
package pipe_pkg;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_HALTED = 2'd2
    } state_e;

    localparam int unsigned STG_IF = 0;
    localparam int unsigned STG_ID = 1;
    localparam int unsigned STG_EX = 2;

    // fwd_sel: 0 reads the register file, any other value k forwards from stage k
    localparam int unsigned FWD_REGFILE = 0;

endpackage

// File: rtl/pipe_scoreboard.sv
// In-flight writer tracking for stages EX..WB; one entry per stage, shifting
// one stage per clock, with branch-squash of younger stages on the way through.
module pipe_scoreboard
    import pipe_pkg::*;
#(
    parameter int unsigned NUM_STAGES = 5,
    parameter int unsigned REG_ADDR_W = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          push,
    input  logic [REG_ADDR_W-1:0]         push_rd,
    input  logic                          push_we,
    input  logic                          push_is_load,
    input  logic [NUM_STAGES-2:STG_EX]    kill,
    output logic [NUM_STAGES-1:STG_EX]    vld,
    output logic [REG_ADDR_W-1:0]         rd [NUM_STAGES-1:STG_EX],
    output logic [NUM_STAGES-1:STG_EX]    we,
    output logic [NUM_STAGES-1:STG_EX]    is_load,
    output logic                          drained_c
);

    // Valid bits carry reset and squash; payload simply follows along.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld <= '0;
        end else begin
            vld[STG_EX] <= push;
            for (int unsigned s = STG_EX + 1; s < NUM_STAGES; s++) begin
                vld[s] <= vld[s-1] & ~kill[s-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        rd[STG_EX]      <= push_rd;
        we[STG_EX]      <= push_we;
        is_load[STG_EX] <= push_is_load;
        for (int unsigned s = STG_EX + 1; s < NUM_STAGES; s++) begin
            rd[s]      <= rd[s-1];
            we[s]      <= we[s-1];
            is_load[s] <= is_load[s-1];
        end
    end

    // True when nothing already in flight survives the next shift (push excluded).
    always_comb begin
        drained_c = 1'b1;
        for (int unsigned s = STG_EX; s < NUM_STAGES - 1; s++) begin
            if (vld[s] && !kill[s]) begin
                drained_c = 1'b0;
            end
        end
    end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline hazard controller: RAW detection with forwarding or stall,
// branch flush, and a RUN/DRAIN/HALTED sequence for the HLT instruction.
module pipe_ctrl
    import pipe_pkg::*;
#(
    parameter int unsigned REG_ADDR_W = 4,
    parameter int unsigned NUM_STAGES = 5,
    parameter int unsigned LOAD_STAGE = 3,
    parameter int unsigned BR_STAGE   = 3,
    parameter int unsigned FWD_EN     = 1
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            id_valid,
    input  logic                            id_is_hlt,
    input  logic [REG_ADDR_W-1:0]           id_rs0,
    input  logic [REG_ADDR_W-1:0]           id_rs1,
    input  logic                            id_rs0_used,
    input  logic                            id_rs1_used,
    input  logic [REG_ADDR_W-1:0]           id_rd,
    input  logic                            id_we,
    input  logic                            id_is_load,
    input  logic                            br_taken,
    output logic                            stall_if_id,
    output logic                            bubble_ex,
    output logic [NUM_STAGES-1:0]           flush,
    output logic [$clog2(NUM_STAGES)-1:0]   fwd_sel0,
    output logic [$clog2(NUM_STAGES)-1:0]   fwd_sel1,
    output logic                            hlt,
    output logic [1:0]                      state
);

    localparam int unsigned SEL_W = $clog2(NUM_STAGES);

    state_e                         state_q;
    state_e                         state_d;
    logic                           br_live;
    logic                           hazard;
    logic                           sb_push;
    logic                           sb_drained_c;
    logic [NUM_STAGES-1:STG_EX]     sb_vld;
    logic [NUM_STAGES-1:STG_EX]     sb_we;
    logic [NUM_STAGES-1:STG_EX]     sb_ld;
    logic [REG_ADDR_W-1:0]          sb_rd [NUM_STAGES-1:STG_EX];

    logic [REG_ADDR_W-1:0]          src [2];
    logic [1:0]                     src_used;
    logic [1:0]                     src_found;
    logic [1:0]                     src_stall;
    logic [SEL_W-1:0]               src_sel [2];

    always_comb begin
        src[0]      = id_rs0;
        src[1]      = id_rs1;
        src_used[0] = id_rs0_used;
        src_used[1] = id_rs1_used;
    end

    // Per source: find the youngest in-flight writer and decide forward vs stall.
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            src_found[i] = 1'b0;
            src_stall[i] = 1'b0;
            src_sel[i]   = SEL_W'(FWD_REGFILE);
            for (int unsigned s = STG_EX; s < NUM_STAGES; s++) begin
                if (!src_found[i] && src_used[i] && (src[i] != '0) &&
                    sb_vld[s] && sb_we[s] && (sb_rd[s] == src[i])) begin
                    src_found[i] = 1'b1;
                    if (FWD_EN != 0) begin
                        if (sb_ld[s] && (s < LOAD_STAGE)) begin
                            src_stall[i] = 1'b1;
                        end else begin
                            src_sel[i] = SEL_W'(s);
                        end
                    end else if (s < NUM_STAGES - 1) begin
                        src_stall[i] = 1'b1;
                    end
                end
            end
        end
    end

    always_comb begin
        hazard   = id_valid && (src_stall != 2'b00);
        fwd_sel0 = id_valid ? src_sel[0] : SEL_W'(FWD_REGFILE);
        fwd_sel1 = id_valid ? src_sel[1] : SEL_W'(FWD_REGFILE);
    end

    // Next state, stall, flush and bubble; a taken branch always beats a stall.
    always_comb begin
        state_d     = state_q;
        stall_if_id = 1'b0;
        flush       = '0;
        br_live     = br_taken && (state_q != ST_HALTED);

        for (int unsigned i = 0; i < NUM_STAGES; i++) begin
            flush[i] = br_live && (i < BR_STAGE);
        end

        case (state_q)
            ST_RUN: begin
                stall_if_id = hazard && !br_taken;
                if (id_valid && id_is_hlt && !hazard && !br_taken) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (br_taken) begin
                    state_d = ST_RUN;
                end else begin
                    stall_if_id = 1'b1;
                    if (sb_drained_c) begin
                        state_d = ST_HALTED;
                    end
                end
            end
            ST_HALTED: begin
                stall_if_id = 1'b1;
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase

        // HLT never occupies a scoreboard slot; it travels on as a bubble.
        bubble_ex = stall_if_id || flush[STG_ID] || (state_q != ST_RUN) ||
                    !id_valid || id_is_hlt;
    end

    always_comb begin
        sb_push = !bubble_ex;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_RUN;
            hlt     <= 1'b0;
        end else begin
            state_q <= state_d;
            hlt     <= (state_d == ST_HALTED);
        end
    end

    always_comb begin
        state = state_q;
    end

    pipe_scoreboard #(
        .NUM_STAGES (NUM_STAGES),
        .REG_ADDR_W (REG_ADDR_W)
    ) u_scoreboard (
        .clk          (clk),
        .rst          (rst),
        .push         (sb_push),
        .push_rd      (id_rd),
        .push_we      (id_we),
        .push_is_load (id_is_load),
        .kill         (flush[NUM_STAGES-2:STG_EX]),
        .vld          (sb_vld),
        .rd           (sb_rd),
        .we           (sb_we),
        .is_load      (sb_ld),
        .drained_c    (sb_drained_c)
    );

endmodule

// File: tb/tb_pipe_ctrl.sv
// Bench for pipe_ctrl: one forwarding and one non-forwarding instance share
// stimulus; each is compared against its own queue-based in-flight model.
module tb_pipe_ctrl;

    localparam int NS = 5;
    localparam int LS = 3;
    localparam int BS = 3;

    logic       clk = 1'b0;
    logic       rst;
    logic       id_valid, id_is_hlt;
    logic [3:0] id_rs0, id_rs1, id_rd;
    logic       id_rs0_used, id_rs1_used, id_we, id_is_load, br_taken;

    logic       a_stall, a_bubble, a_hlt, b_stall, b_bubble, b_hlt;
    logic [4:0] a_flush, b_flush;
    logic [2:0] a_sel0, a_sel1, b_sel0, b_sel1;
    logic [1:0] a_state, b_state;

    always #5 clk = ~clk;

    pipe_ctrl #(.REG_ADDR_W(4), .NUM_STAGES(5), .LOAD_STAGE(3), .BR_STAGE(3), .FWD_EN(1)) dut_a (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_is_hlt(id_is_hlt),
        .id_rs0(id_rs0), .id_rs1(id_rs1), .id_rs0_used(id_rs0_used), .id_rs1_used(id_rs1_used),
        .id_rd(id_rd), .id_we(id_we), .id_is_load(id_is_load), .br_taken(br_taken),
        .stall_if_id(a_stall), .bubble_ex(a_bubble), .flush(a_flush),
        .fwd_sel0(a_sel0), .fwd_sel1(a_sel1), .hlt(a_hlt), .state(a_state));

    pipe_ctrl #(.REG_ADDR_W(4), .NUM_STAGES(5), .LOAD_STAGE(3), .BR_STAGE(3), .FWD_EN(0)) dut_b (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_is_hlt(id_is_hlt),
        .id_rs0(id_rs0), .id_rs1(id_rs1), .id_rs0_used(id_rs0_used), .id_rs1_used(id_rs1_used),
        .id_rd(id_rd), .id_we(id_we), .id_is_load(id_is_load), .br_taken(br_taken),
        .stall_if_id(b_stall), .bubble_ex(b_bubble), .flush(b_flush),
        .fwd_sel0(b_sel0), .fwd_sel1(b_sel1), .hlt(b_hlt), .state(b_state));

    // Model: list of in-flight writers tagged by instance (0 = forwarding, 1 = not)
    typedef struct {
        int         m;
        int         stg;
        logic [3:0] rd;
        bit         we;
        bit         ld;
    } ent_t;

    ent_t       q[$];
    int         st [2];
    bit         e_stall [2];
    bit         e_bubble [2];
    logic [4:0] e_flush [2];
    logic [2:0] e_sel0 [2];
    logic [2:0] e_sel1 [2];
    int         checks = 0;
    int         failures = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic calc(input int m);
        logic [3:0] rs;
        bit         used;
        int         best_stg;
        bit         best_ld;
        bit         hzs [2];
        logic [2:0] sel [2];
        bit         hz;
        bit         br_live;
        for (int i = 0; i < 2; i++) begin
            rs       = (i == 0) ? id_rs0 : id_rs1;
            used     = (i == 0) ? id_rs0_used : id_rs1_used;
            best_stg = -1;
            best_ld  = 1'b0;
            foreach (q[k]) begin
                if (q[k].m == m && q[k].we && used && rs != 4'd0 && q[k].rd == rs &&
                    (best_stg < 0 || q[k].stg < best_stg)) begin
                    best_stg = q[k].stg;
                    best_ld  = q[k].ld;
                end
            end
            hzs[i] = 1'b0;
            sel[i] = 3'd0;
            if (best_stg >= 0) begin
                if (m == 0) begin
                    if (best_ld && best_stg < LS) hzs[i] = 1'b1;
                    else sel[i] = 3'(best_stg);
                end else if (best_stg < NS - 1) begin
                    hzs[i] = 1'b1;
                end
            end
        end
        hz        = id_valid && (hzs[0] || hzs[1]);
        e_sel0[m] = id_valid ? sel[0] : 3'd0;
        e_sel1[m] = id_valid ? sel[1] : 3'd0;
        br_live   = br_taken && st[m] != 2;
        e_flush[m] = br_live ? 5'((1 << BS) - 1) : 5'd0;
        case (st[m])
            0:       e_stall[m] = hz && !br_taken;
            1:       e_stall[m] = !br_taken;
            default: e_stall[m] = 1'b1;
        endcase
        e_bubble[m] = e_stall[m] || e_flush[m][1] || st[m] != 0 || !id_valid || id_is_hlt;
    endtask

    task automatic upd(input int m);
        ent_t nq[$];
        ent_t e;
        bit   br_live;
        bit   empty;
        br_live = br_taken && st[m] != 2;
        if (rst) begin
            foreach (q[k]) if (q[k].m != m) nq.push_back(q[k]);
            q     = nq;
            st[m] = 0;
            return;
        end
        foreach (q[k]) begin
            e = q[k];
            if (e.m != m) begin
                nq.push_back(e);
            end else if (!(br_live && e.stg < BS)) begin
                e.stg++;
                if (e.stg < NS) nq.push_back(e);
            end
        end
        if (!e_bubble[m]) begin
            e.m = m; e.stg = 2; e.rd = id_rd; e.we = id_we; e.ld = id_is_load;
            nq.push_back(e);
        end
        q = nq;
        empty = 1'b1;
        foreach (q[k]) if (q[k].m == m) empty = 1'b0;
        case (st[m])
            0: if (id_valid && id_is_hlt && !e_stall[m] && !br_taken) st[m] = 1;
            1: if (br_taken) st[m] = 0; else if (empty) st[m] = 2;
            default: ;
        endcase
    endtask

    // One clock: compare both instances mid-cycle, then advance both models.
    task automatic step();
        @(negedge clk);
        calc(0);
        calc(1);
        chk("a_stall",  a_stall,  e_stall[0]);
        chk("a_bubble", a_bubble, e_bubble[0]);
        chk("a_flush",  a_flush,  e_flush[0]);
        chk("a_sel0",   a_sel0,   e_sel0[0]);
        chk("a_sel1",   a_sel1,   e_sel1[0]);
        chk("a_hlt",    a_hlt,    st[0] == 2);
        chk("a_state",  a_state,  st[0]);
        chk("b_stall",  b_stall,  e_stall[1]);
        chk("b_bubble", b_bubble, e_bubble[1]);
        chk("b_flush",  b_flush,  e_flush[1]);
        chk("b_sel0",   b_sel0,   e_sel0[1]);
        chk("b_sel1",   b_sel1,   e_sel1[1]);
        chk("b_hlt",    b_hlt,    st[1] == 2);
        chk("b_state",  b_state,  st[1]);
        @(posedge clk);
        upd(0);
        upd(1);
        #1;
    endtask

    task automatic idle();
        id_valid = 0; id_is_hlt = 0; id_rs0 = 0; id_rs1 = 0; id_rs0_used = 0;
        id_rs1_used = 0; id_rd = 0; id_we = 0; id_is_load = 0; br_taken = 0;
    endtask

    task automatic ins(input logic [3:0] rd, input bit we, input bit ld,
                       input logic [3:0] rs0, input bit u0);
        idle();
        id_valid = 1; id_rd = rd; id_we = we; id_is_load = ld;
        id_rs0 = rs0; id_rs0_used = u0;
    endtask

    task automatic hlt_ins();
        idle();
        id_valid = 1; id_is_hlt = 1;
    endtask

    task automatic do_reset();
        idle();
        rst = 1;
        step();
        rst = 0;
    endtask

    initial begin
        idle();
        rst = 1;
        st[0] = 0; st[1] = 0;
        repeat (2) @(posedge clk);
        #1;
        rst = 0;

        // Reset state
        #1;
        chk("rst_hlt", a_hlt, 0);
        chk("rst_stall", a_stall, 0);
        chk("rst_fwd0", a_sel0, 0);
        chk("rst_fwd1", a_sel1, 0);
        chk("rst_flush", a_flush, 0);
        chk("rst_state", a_state, 0);
        step();

        // Load-use: one stall, then forward from stage 3
        ins(3, 1, 1, 0, 0); step();
        ins(0, 0, 0, 3, 1);
        #1; chk("lu_stall", a_stall, 1); chk("lu_bubble", a_bubble, 1);
        step();
        #1; chk("lu_release", a_stall, 0); chk("lu_bubble_off", a_bubble, 0); chk("lu_fwd", a_sel0, 3);
        step();

        // ALU RAW: forward from EX; non-forwarding instance stalls two cycles
        do_reset();
        ins(2, 1, 0, 0, 0); step();
        ins(0, 0, 0, 2, 1);
        #1; chk("raw_stall", a_stall, 0); chk("raw_fwd", a_sel0, 2); chk("nofwd_stall1", b_stall, 1);
        step();
        #1; chk("nofwd_stall2", b_stall, 1); chk("raw_fwd_s3", a_sel0, 3);
        step();
        #1; chk("nofwd_release", b_stall, 0); chk("nofwd_sel", b_sel0, 0);
        step();

        // Writes to R0 never forward or stall
        do_reset();
        ins(0, 1, 0, 0, 0); step();
        ins(0, 0, 0, 0, 1);
        #1; chk("r0_fwd", a_sel0, 0); chk("r0_nofwd_stall", b_stall, 0);
        step();

        // Branch during load-use stall
        do_reset();
        ins(3, 1, 1, 0, 0); step();
        ins(0, 0, 0, 3, 1); br_taken = 1;
        #1; chk("br_flush", a_flush, 5'b00111); chk("br_stall", a_stall, 0);
        step();
        br_taken = 0;
        #1; chk("br_killed_stall", a_stall, 0); chk("br_killed_fwd", a_sel0, 0);
        step();

        // Halt with a full pipe
        do_reset();
        ins(5, 1, 0, 0, 0); step();
        ins(6, 1, 0, 0, 0); step();
        ins(7, 1, 0, 0, 0); step();
        hlt_ins(); step();
        idle();
        #1; chk("halt_c1_state", a_state, 1); chk("halt_c1_hlt", a_hlt, 0);
        step();
        #1; chk("halt_c2_hlt", a_hlt, 0); step();
        #1; chk("halt_c3_hlt", a_hlt, 1); step();
        #1; chk("halt_c4_hlt", a_hlt, 1); chk("halt_c4_state", a_state, 2);
        br_taken = 1;
        #1; chk("halted_flush", a_flush, 0); chk("halted_stall", a_stall, 1);
        step();
        br_taken = 0;
        #1; chk("halted_keep", a_hlt, 1); step();

        // Halt with an empty pipe
        do_reset();
        hlt_ins(); step();
        idle();
        #1; chk("halt_empty_c1", a_state, 1); step();
        #1; chk("halt_empty_c2", a_hlt, 1); step();

        // Reset in DRAIN
        do_reset();
        ins(5, 1, 0, 0, 0); step();
        hlt_ins(); step();
        idle(); rst = 1;
        #1; chk("drain_pre_rst", a_state, 1);
        step();
        rst = 0;
        #1; chk("drain_rst_state", a_state, 0); chk("drain_rst_hlt", a_hlt, 0);
        ins(0, 0, 0, 5, 1);
        #1; chk("drain_rst_empty", a_sel0, 0); chk("drain_rst_nostall", a_stall, 0);
        step();

        // Taken branch in DRAIN resumes RUN
        do_reset();
        ins(5, 1, 0, 0, 0); step();
        hlt_ins(); step();
        idle(); br_taken = 1;
        #1; chk("drain_br_stall", a_stall, 0); chk("drain_br_flush", a_flush, 5'b00111);
        step();
        br_taken = 0;
        #1; chk("drain_br_state", a_state, 0);
        step();

        // Randomised traffic on a small register set to provoke hazards
        for (int n = 0; n < 600; n++) begin
            rst         = ($urandom_range(0, 39) == 0);
            id_valid    = ($urandom_range(0, 3) != 0);
            id_is_hlt   = ($urandom_range(0, 49) == 0);
            id_rs0      = 4'($urandom_range(0, 3));
            id_rs1      = 4'($urandom_range(0, 3));
            id_rs0_used = 1'($urandom_range(0, 1));
            id_rs1_used = 1'($urandom_range(0, 1));
            id_rd       = 4'($urandom_range(0, 3));
            id_we       = 1'($urandom_range(0, 1));
            id_is_load  = ($urandom_range(0, 2) == 0);
            br_taken    = ($urandom_range(0, 9) == 0);
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
